ha_serial_adder_ctrl: RTL and testbench
=======================================

Name: ha_serial_adder_ctrl

Overview:
Bit-serial adder controller that reuses one full-adder cell, built from two half-adder stages plus an OR, over WIDTH cycles.
- Operands are latched on a start handshake; the block steps through one bit per clock from LSB to MSB and reports sum/carry with a done pulse.
- Serves as the area-minimal arithmetic unit for slow-path accumulation in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (legal 1..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse/level; sampled only in IDLE
a  input  WIDTH  operand A, latched on accepted start
b  input  WIDTH  operand B, latched on accepted start
busy  output  1  high while operation in progress (RUN and DONE)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry out, held with sum

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears internal shift registers, carry and counter.
- States: IDLE, RUN, DONE (2-bit encoding, free choice).
- IDLE:
  - start=1 at an edge: latch a into sh_a and b into sh_b; carry=0, cnt=0, busy=1, go to RUN.
  - sum/cout keep their previous values until the first RUN edge.
- RUN, once per edge:
  - s1 = sh_a[0]^sh_b[0]; c1 = sh_a[0]&sh_b[0]
  - s = s1^carry; c2 = s1&carry; carry <= c1|c2
  - sum <= {s, sum[WIDTH-1:1]} (shift in at MSB)
  - sh_a, sh_b shift right one bit; cnt <= cnt+1
  - When cnt==WIDTH-1 on this edge: go to DONE, done<=1, cout<=c1|c2.
- DONE: lasts exactly one cycle with done=1 and busy=1. The next edge goes to IDLE with done=0 and busy=0.
- Latency:
  - Start accepted at edge k; done high in the cycle after edge k+WIDTH.
  - Busy is high for WIDTH+1 cycles.
  - Throughput is one operation per WIDTH+2 cycles.
- Handshake:
  - start in RUN or DONE is ignored; it is not queued.
  - Operand changes after acceptance have no effect.
- sum holds partial results during RUN. It is valid only when done=1 and afterwards until the next accepted start.
- Wrap-around: result is modulo 2^WIDTH and cout carries the overflow, e.g. all-ones + 1 gives sum=0, cout=1.
- WIDTH=1: RUN lasts one cycle; behaviour is identical to a half adder with registered outputs.
- Reset mid-RUN: the operation is aborted, no done pulse, outputs=0. The first start after reset release is accepted normally.

Optional Feature:
Macro HA_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands.
  - sub=1 makes RUN use ~sh_b[0] and initialises carry=1, so sum=a-b mod 2^WIDTH and cout=1 means no borrow (a>=b).
  - sub=0 is identical to the add path.
- Undefined: no sub port; add only.
- Timing is identical in both builds.

Test Plan:
- WIDTH=8, start with a=0x5A, b=0x33 -> done exactly 8 cycles after the accepting edge, sum=0x8D, cout=0, busy high 9 cycles.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0x00, b=0x00 -> sum=0x00, cout=0.
- Start held high through RUN with operands changed to 0x11/0x22 mid-run -> first result unaffected (0x5A+0x33), one done pulse only, and the second op starts only from IDLE.
- rst_n low for 2 cycles at cnt=4 of a run -> busy/done/sum/cout=0 immediately, no done pulse; next start a=0x01, b=0x02 -> sum=0x03.
- WIDTH=1 sweep over all 4 {a,b} -> sum/cout = 0/0, 1/0, 1/0, 0/1, each done 1 cycle after acceptance.
- HA_SERIAL_SUB_EN, WIDTH=8: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x01, b=0x02 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/ha_serial_adder_ctrl.sv
// ha_serial_adder_ctrl: bit-serial adder that reuses one full-adder cell,
// built from two half-adder stages and an OR, once per clock over WIDTH
// cycles. Operands are captured on an accepted start in IDLE. The result
// shifts into sum from the MSB end. A one-cycle done pulse marks the final
// result, and cout holds the final carry.
//
// Optional build macro HA_SERIAL_SUB_EN adds a 'sub' input. When sub=1, the
// block computes a-b mod 2^WIDTH, and cout=1 means there was no borrow.
// Timing is the same with or without this macro.
module ha_serial_adder_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef HA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Operand bit that enters the cell; for subtraction it is inverted.
  logic             bit_b;
`ifdef HA_SERIAL_SUB_EN
  logic             sub_q;
  assign bit_b = sub_q ? ~sh_b[0] : sh_b[0];
`else
  assign bit_b = sh_b[0];
`endif

  // Full-adder cell: half adder on the operand bits, a second half adder
  // with the running carry, and an OR of the two partial carries.
  logic s1, c1, s, c2, carry_next;
  assign s1         = sh_a[0] ^ bit_b;
  assign c1         = sh_a[0] & bit_b;
  assign s          = s1 ^ carry;
  assign c2         = s1 & carry;
  assign carry_next = c1 | c2;

  // The new sum bit goes in at the MSB. A one-bit result has nothing to shift.
  logic [WIDTH-1:0] sum_shift;
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = s;
    end else begin : g_wn
      assign sum_shift = {s, sum[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef HA_SERIAL_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef HA_SERIAL_SUB_EN
            sub_q <= sub;
            // Subtraction adds a plus the inverse of b plus one; the "+1"
            // comes from starting with the carry already set.
            carry <= sub;
`else
            carry <= 1'b0;
`endif
          end
        end
        RUN: begin
          carry <= carry_next;
          sum   <= sum_shift;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= DONE;
            done  <= 1'b1;
            cout  <= carry_next;
          end
        end
        DONE: begin
          // A start that arrives here is ignored. Only IDLE samples start.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha_serial_adder_ctrl.sv
// Directed testbench for ha_serial_adder_ctrl. It drives a WIDTH=8 instance
// and a WIDTH=1 instance from the same clock.
module tb_ha_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8, sum8;
  logic [0:0] a1, b1, sum1;
  logic       busy8, done8, cout8;
  logic       busy1, done1, cout1;
`ifdef HA_SERIAL_SUB_EN
  logic       sub8, sub1;
`endif

  int checks = 0;
  int passes = 0;
  int n, dn, busy_cnt;
  logic [7:0] last_sum8;

  always #5 clk = ~clk;

  ha_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef HA_SERIAL_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  ha_serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
`ifdef HA_SERIAL_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Run one 8-bit operation, then check latency, busy length and the result.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic [7:0] esum, input logic ecout, input string tag);
    @(negedge clk);
    a8 = ta; b8 = tb_v; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({tag, "_busy_on_accept"}, busy8, 1);
    chk({tag, "_sum_held_at_accept"}, sum8, last_sum8);
    busy_cnt = busy8 ? 1 : 0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy8) busy_cnt++;
      if (done8) break;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_sum"}, sum8, esum);
    chk({tag, "_cout"}, cout8, ecout);
    @(posedge clk); #1;
    chk({tag, "_busy_cycles"}, busy_cnt, 9);
    chk({tag, "_idle_after"}, {busy8, done8}, 0);
    chk({tag, "_sum_held_after"}, sum8, esum);
    last_sum8 = esum;
    $display("op8 %s: a=%02h b=%02h sum=%02h cout=%0d latency=%0d", tag, ta, tb_v, sum8, cout8, n);
  endtask

  // Run one 1-bit operation on the WIDTH=1 instance.
  task automatic op1(input logic ta, input logic tb_v, input logic es, input logic ec,
                     input string tag);
    @(negedge clk);
    a1 = ta; b1 = tb_v; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk({tag, "_busy_on_accept"}, busy1, 1);
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      if (done1) break;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_sum"}, sum1, es);
    chk({tag, "_cout"}, cout1, ec);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {busy1, done1}, 0);
    $display("op1 %s: a=%0d b=%0d sum=%0d cout=%0d latency=%0d", tag, ta, tb_v, sum1, cout1, n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
`ifdef HA_SERIAL_SUB_EN
    sub8 = 1'b0; sub1 = 1'b0;
`endif
    last_sum8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state8", {busy8, done8, cout8, sum8}, 0);
    chk("reset_state1", {busy1, done1, cout1, sum1}, 0);
    $display("reset: busy8=%0d done8=%0d sum8=%02h cout8=%0d", busy8, done8, sum8, cout8);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'h5A, 8'h33, 8'h8D, 1'b0, "add_5a_33");
    op8(8'hFF, 8'h01, 8'h00, 1'b1, "wrap_ff_01");
    op8(8'h00, 8'h00, 8'h00, 1'b0, "zero_00_00");

    // Hold start high through RUN and change the operands after acceptance.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22;
    chk("held_busy_on_accept", busy8, 1);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done8) dn++;
    end
    chk("held_sum_first", sum8, 8'h8D);
    chk("held_cout_first", cout8, 0);
    @(posedge clk); #1;
    chk("held_idle_between", {busy8, done8}, 0);
    chk("held_one_done", dn, 1);
    @(posedge clk); #1;
    chk("held_second_accept", busy8, 1);
    chk("held_sum_kept", sum8, 8'h8D);
    start8 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done8) break;
    end
    chk("held_second_latency", n, 8);
    chk("held_second_sum", sum8, 8'h33);
    chk("held_second_cout", cout8, 0);
    $display("held: first=8d second sum=%02h cout=%0d", sum8, cout8);
    @(posedge clk); #1;
    last_sum8 = 8'h33;

    // Assert reset when cnt=4 in the middle of a run.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs_zero", {busy8, done8, cout8, sum8}, 0);
    dn = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done8) dn++;
    end
    chk("midrst_no_done", dn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done8 || busy8) dn++;
    end
    chk("midrst_stays_idle", dn, 0);
    $display("midrst: busy8=%0d done8=%0d sum8=%02h cout8=%0d", busy8, done8, sum8, cout8);
    last_sum8 = 8'h00;
    op8(8'h01, 8'h02, 8'h03, 1'b0, "post_rst_01_02");

    op1(1'b0, 1'b0, 1'b0, 1'b0, "w1_00");
    op1(1'b0, 1'b1, 1'b1, 1'b0, "w1_01");
    op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_10");
    op1(1'b1, 1'b1, 1'b0, 1'b1, "w1_11");

`ifdef HA_SERIAL_SUB_EN
    sub8 = 1'b1;
    op8(8'h10, 8'h01, 8'h0F, 1'b1, "sub_10_01");
    op8(8'h01, 8'h02, 8'hFF, 1'b0, "sub_01_02");
    sub8 = 1'b0;
    op8(8'h10, 8'h01, 8'h11, 1'b0, "sub0_add_10_01");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
